// File: rtl/entropy_word_dispenser.sv
// entropy_word_dispenser
// Consumer side of the audio-entropy pool. Counts rising edges of the AC97
// sample strobe, and once the whole pool has been refreshed it snapshots the
// pool and serves it as WORD_WIDTH-bit words over a valid/ready handshake,
// least-significant word first. A snapshot is never served twice.
//
// Optional build macro: ENTROPY_HEALTH_EN
//   When defined, each snapshot is health-checked (all-zeros, all-ones or a
//   repeat of the previous accepted snapshot are rejected) and health_fail
//   pulses for one cycle on rejection. When undefined, health_fail is tied 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FRESH | waiting for REFRESH_BITS fresh sample edges (starved=1)
// SNAPSHOT   | one-cycle capture of the pool into the shadow register
// SERVE      | presenting shadow words to the consumer (word_valid=1)

module entropy_word_dispenser #(
  parameter int POOL_WIDTH   = 256,
  parameter int WORD_WIDTH   = 32,
  parameter int REFRESH_BITS = 256
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [POOL_WIDTH-1:0]                 pool,
  input  logic                                  sample_ready,
  input  logic                                  word_ready,
  output logic [WORD_WIDTH-1:0]                 word,
  output logic                                  word_valid,
  output logic [$clog2(POOL_WIDTH/WORD_WIDTH):0] words_left,
  output logic                                  starved,
  output logic                                  health_fail
);

  localparam int NUM_WORDS = POOL_WIDTH / WORD_WIDTH;
  localparam int LEFT_W    = $clog2(NUM_WORDS) + 1;

  localparam logic [15:0]       REFRESH_MAX = 16'(REFRESH_BITS);
  localparam logic [LEFT_W-1:0] WORDS_FULL  = LEFT_W'(NUM_WORDS);
  localparam logic [LEFT_W-1:0] WORDS_ONE   = LEFT_W'(1);

  typedef enum logic [1:0] {
    WAIT_FRESH = 2'd0,
    SNAPSHOT   = 2'd1,
    SERVE      = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    prev_sample;
  logic                    sample_edge;
  logic [15:0]             fresh_cnt;
  logic                    fresh_full;
  logic [POOL_WIDTH-1:0]   shadow;
  logic                    accept;
  logic                    last_word;
  logic                    snap_ok;
  logic                    snap_take;

  assign sample_edge = sample_ready & ~prev_sample;
  assign fresh_full  = (fresh_cnt == REFRESH_MAX);
  assign accept      = (state == SERVE) & word_ready;
  assign last_word   = (words_left == WORDS_ONE);
  assign snap_take   = (state == SNAPSHOT) & snap_ok;

`ifdef ENTROPY_HEALTH_EN
  logic [POOL_WIDTH-1:0] last_snap;

  // A degenerate or repeated pool means the source is stuck; refuse it.
  assign snap_ok = (pool != '0) && (pool != '1) && (pool != last_snap);

  // Remember the last accepted snapshot for the repeat check.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_snap <= '0;
    end else if (snap_take) begin
      last_snap <= pool;
    end
  end

  // Registered one-cycle pulse raised by a rejected snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      health_fail <= 1'b0;
    end else begin
      health_fail <= (state == SNAPSHOT) & ~snap_ok;
    end
  end
`else
  assign snap_ok     = 1'b1;
  assign health_fail = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_FRESH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs. A back-to-back refresh goes
  // straight from the last accepted word into SNAPSHOT, so word_valid is
  // low only for that single capture cycle.
  always_comb begin
    state_next = state;
    word_valid = 1'b0;
    starved    = 1'b0;
    case (state)
      WAIT_FRESH: begin
        starved = 1'b1;
        if (fresh_full) begin
          state_next = SNAPSHOT;
        end
      end
      SNAPSHOT: begin
        state_next = snap_ok ? SERVE : WAIT_FRESH;
      end
      SERVE: begin
        word_valid = 1'b1;
        if (word_ready && last_word) begin
          state_next = fresh_full ? SNAPSHOT : WAIT_FRESH;
        end
      end
      default: begin
        state_next = WAIT_FRESH;
      end
    endcase
  end

  // Sample strobe edge detector; a strobe already high at reset release
  // counts as an edge because prev_sample comes out of reset low.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_sample <= 1'b0;
    end else begin
      prev_sample <= sample_ready;
    end
  end

  // Fresh-bit counter: saturating, cleared by the capture cycle but still
  // crediting an edge that lands in that same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      fresh_cnt <= '0;
    end else if (state == SNAPSHOT) begin
      fresh_cnt <= {15'd0, sample_edge};
    end else if (sample_edge && !fresh_full) begin
      fresh_cnt <= fresh_cnt + 16'd1;
    end
  end

  // Shadow copy of the pool and its remaining-word count; words leave from
  // the bottom and the vacated top is zero-filled.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      words_left <= '0;
    end else if (snap_take) begin
      shadow     <= pool;
      words_left <= WORDS_FULL;
    end else if (accept) begin
      shadow     <= shadow >> WORD_WIDTH;
      words_left <= words_left - WORDS_ONE;
    end
  end

  assign word = word_valid ? shadow[WORD_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_entropy_word_dispenser.sv
// Testbench for entropy_word_dispenser: a vector table for the first served
// snapshot, hand-written multi-cycle sequences, and randomized traffic, all
// checked every cycle against a queue-based reference model.

module tb_entropy_word_dispenser;

  localparam int POOL_W  = 256;
  localparam int WORD_W  = 32;
  localparam int NWORDS  = POOL_W / WORD_W;
  localparam int REFRESH = 256;

  logic              clock = 1'b0;
  logic              reset;
  logic [POOL_W-1:0] pool;
  logic              sample_ready;
  logic              word_ready;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic [3:0]        words_left;
  logic              starved;
  logic              health_fail;

  int checks   = 0;
  int failures = 0;

  entropy_word_dispenser #(
    .POOL_WIDTH  (POOL_W),
    .WORD_WIDTH  (WORD_W),
    .REFRESH_BITS(REFRESH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pool        (pool),
    .sample_ready(sample_ready),
    .word_ready  (word_ready),
    .word        (word),
    .word_valid  (word_valid),
    .words_left  (words_left),
    .starved     (starved),
    .health_fail (health_fail)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Reference model: pending words held in a queue.
  int                m_fresh;
  bit                m_prev;
  bit                m_snap;
  bit                m_hf;
  logic [WORD_W-1:0] m_q[$];
  logic [POOL_W-1:0] m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    bit edge_now;
    bit ok;
    if (reset) begin
      m_fresh = 0; m_prev = 0; m_snap = 0; m_hf = 0; m_last = '0;
      m_q.delete();
      return;
    end
    edge_now = sample_ready && !m_prev;
    m_prev   = sample_ready;
    m_hf     = 0;
    if (m_snap) begin
      m_snap = 0;
      ok = 1;
`ifdef ENTROPY_HEALTH_EN
      ok = (pool != '0) && (pool != '1) && (pool != m_last);
      if (ok) m_last = pool;
      m_hf = !ok;
`endif
      if (ok) for (int i = 0; i < NWORDS; i++) m_q.push_back(pool[i*WORD_W +: WORD_W]);
      m_fresh = edge_now ? 1 : 0;
    end else begin
      if (m_q.size() > 0) begin
        if (word_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0 && m_fresh == REFRESH) m_snap = 1;
        end
      end else if (m_fresh == REFRESH) begin
        m_snap = 1;
      end
      if (edge_now && m_fresh < REFRESH) m_fresh++;
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (m_q.size() > 0);
    chk("valid", word_valid, ev);
    chk("word", word, ev ? m_q[0] : '0);
    chk("words_left", words_left, m_q.size());
    chk("starved", starved, !ev && !m_snap);
    chk("health_fail", health_fail, m_hf);
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic feed_edges(input int n);
    for (int i = 0; i < n; i++) begin
      sample_ready = 1'b1; tick();
      sample_ready = 1'b0; tick();
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!word_valid && n < budget) begin tick(); n++; end
    chk(name, word_valid, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    word_ready = 1'b1;
    while (word_valid && n < 20) begin tick(); n++; end
    chk(name, word_valid, 1'b0);
    word_ready = 1'b0;
  endtask

  task automatic rand_pool();
    for (int i = 0; i < NWORDS; i++) pool[i*WORD_W +: WORD_W] = $urandom;
  endtask

  typedef struct {
    logic              wr;
    logic              exp_valid;
    logic [WORD_W-1:0] exp_word;
    logic [3:0]        exp_left;
    logic              exp_starved;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [POOL_W-1:0] p2;
    logic [POOL_W-1:0] q;
    int n, gap, hf_cnt;
    bit saw_v;

    // Backpressure for 5 cycles, then 8 words back-to-back, then starved.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b1, 32'd0, 4'd8, 1'b0};
    for (int i = 0; i < 8; i++) tbl[5+i] = '{1'b1, 1'b1, 32'(i), 4'(8 - i), 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1};

    reset = 1'b1; sample_ready = 1'b0; word_ready = 1'b0; pool = '0;
    for (int i = 0; i < NWORDS; i++) pool[i*WORD_W +: WORD_W] = 32'(i);
    repeat (2) begin @(posedge clock); model_step(); #1; end
    reset = 1'b0;

    chk("rst_word", word, 32'd0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_left", words_left, 4'd0);
    chk("rst_starved", starved, 1'b1);
    chk("rst_hf", health_fail, 1'b0);

    // 255 edges are not enough; the 256th at edge k gives valid after k+2.
    feed_edges(255);
    chk("pre_valid", word_valid, 1'b0);
    chk("pre_starved", starved, 1'b1);
    sample_ready = 1'b1; tick();
    chk("lat_k", word_valid, 1'b0);
    tick();
    chk("lat_k1", word_valid, 1'b0);
    sample_ready = 1'b0; tick();
    chk("lat_k2_valid", word_valid, 1'b1);
    chk("lat_k2_left", words_left, 4'd8);

    for (int i = 0; i < 14; i++) begin
      word_ready = tbl[i].wr;
      chk("tbl_valid", word_valid, tbl[i].exp_valid);
      chk("tbl_word", word, tbl[i].exp_word);
      chk("tbl_left", words_left, tbl[i].exp_left);
      chk("tbl_starved", starved, tbl[i].exp_starved);
      tick();
    end
    word_ready = 1'b0;

    // Refresh completes during SERVE: straight into the next snapshot.
    rand_pool();
    feed_edges(REFRESH);
    wait_valid("b2b_first_valid", 10);
    rand_pool(); p2 = pool;
    for (int e = 0; e < REFRESH; e++) begin
      sample_ready = 1'b1;
      word_ready = (m_q.size() > 1) && ($urandom_range(0, 1) == 1);
      tick();
      sample_ready = 1'b0;
      word_ready = (m_q.size() > 1) && ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("b2b_still_valid", word_valid, 1'b1);
    word_ready = 1'b1;
    n = 0;
    while (word_valid && n < 20) begin tick(); n++; end
    gap = 0;
    while (!word_valid && gap < 10) begin tick(); gap++; end
    chk("b2b_gap", gap, 1);
    chk("b2b_word", word, p2[WORD_W-1:0]);
    chk("b2b_left", words_left, 4'd8);
    drain("b2b_drain");

    // Reset after three accepted words discards the rest.
    feed_edges(REFRESH);
    wait_valid("rst_mid_valid", 10);
    word_ready = 1'b1;
    repeat (3) tick();
    word_ready = 1'b0;
    reset = 1'b1; sample_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_valid0", word_valid, 1'b0);
    chk("rst_mid_left0", words_left, 4'd0);
    chk("rst_mid_starved", starved, 1'b1);
    tick();                       // strobe high at release: edge #1
    sample_ready = 1'b0; tick();
    feed_edges(REFRESH - 2);      // total 255
    tick(); tick(); tick();
    chk("rst_mid_255", word_valid, 1'b0);
    feed_edges(1);
    wait_valid("rst_mid_256", 5);
    drain("rst_mid_drain");

    // Constant pool over two refresh periods, then an all-ones pool.
    rand_pool(); q = pool;
    feed_edges(REFRESH);
    wait_valid("const_first", 5);
    drain("const_first_drain");
    for (int r = 0; r < 2; r++) begin
      pool = (r == 0) ? q : '1;
      feed_edges(REFRESH);
      saw_v = 0; hf_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        if (word_valid) saw_v = 1;
        if (health_fail) hf_cnt++;
        tick();
      end
`ifdef ENTROPY_HEALTH_EN
      chk("health_pulses", hf_cnt, 1);
      chk("health_no_valid", saw_v, 1'b0);
`else
      chk("nohealth_pulses", hf_cnt, 0);
      chk("nohealth_served", saw_v, 1'b1);
      drain("nohealth_drain");
`endif
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      sample_ready = $urandom_range(0, 1) == 1;
      word_ready   = $urandom_range(0, 2) != 0;
      reset        = ($urandom_range(0, 699) == 0);
      rand_pool();
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
